// File: rtl/rsa_ctrl_fsm_v2.sv
// Control sequencer for the RSA modular-exponentiation datapath.
// Runs map, one LSB-first square-and-multiply round per exponent bit, and remap, with a start/done/abort handshake.
`timescale 1ns/1ps
module rsa_ctrl_fsm_v2 #(
  parameter int WIDTH     = 8,
  parameter int EXP_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rstb,
  input  logic                           ena,
  input  logic                           start,
  input  logic                           abort,
  input  logic [EXP_WIDTH-1:0]           expE,
  output logic                           rst_mmm,
  output logic                           ld_a,
  output logic                           ld_r,
  output logic                           lock1,
  output logic                           lock2,
  output logic [1:0]                     sel1,
  output logic                           sel2,
  output logic                           busy,
  output logic                           eoc,
  output logic [$clog2(EXP_WIDTH+1)-1:0] round
);

  localparam int STEP_W  = $clog2(WIDTH+1);
  localparam int ROUND_W = $clog2(EXP_WIDTH+1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH);

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_PRE_MAP    = 4'd1,
    ST_MAP        = 4'd2,
    ST_POST_MAP   = 4'd3,
    ST_PRE_MMM    = 4'd4,
    ST_MMM        = 4'd5,
    ST_POST_MMM   = 4'd6,
    ST_PRE_REMAP  = 4'd7,
    ST_REMAP      = 4'd8,
    ST_POST_REMAP = 4'd9,
    ST_DONE       = 4'd10
  } state_t;

  state_t                 state_r, state_s;
  logic [STEP_W-1:0]      step_r, step_s;
  logic [ROUND_W-1:0]     round_r, round_s;
  logic [EXP_WIDTH-1:0]   reg_exp_r, reg_exp_s;
  logic                   step_last_s;
  logic                   in_busy_s;
  logic [EXP_WIDTH-1:0]   exp_shift_s;

  assign step_last_s = (step_r == STEP_LAST);
  assign exp_shift_s = reg_exp_r >> 1;
  assign round       = round_r;

  // State and counter registers; ena freezes everything
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r   <= ST_IDLE;
      step_r    <= '0;
      round_r   <= '0;
      reg_exp_r <= '0;
    end else if (ena) begin
      state_r   <= state_s;
      step_r    <= step_s;
      round_r   <= round_s;
      reg_exp_r <= reg_exp_s;
    end
  end

  // Busy-state decode shared by abort qualification
  always_comb begin
    case (state_r)
      ST_PRE_MAP, ST_MAP, ST_POST_MAP,
      ST_PRE_MMM, ST_MMM, ST_POST_MMM,
      ST_PRE_REMAP, ST_REMAP, ST_POST_REMAP: in_busy_s = 1'b1;
      default:                               in_busy_s = 1'b0;
    endcase
  end

  // Next-state and counter update logic
  always_comb begin
    state_s   = state_r;
    step_s    = step_r;
    round_s   = round_r;
    reg_exp_s = reg_exp_r;
    case (state_r)
      ST_IDLE: begin
        step_s  = '0;
        round_s = '0;
        if (start) begin
          reg_exp_s = expE;
          state_s   = ST_PRE_MAP;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_PRE_MAP: state_s = ST_MAP;
      ST_MAP: begin
        if (step_last_s) begin
          state_s = ST_POST_MAP;
        end else begin
          step_s  = step_r + STEP_W'(1);
        end
      end
      ST_POST_MAP: begin
        step_s = '0;
        if (reg_exp_r == '0) begin
          state_s = ST_PRE_REMAP;
        end else begin
          state_s = ST_PRE_MMM;
        end
      end
      ST_PRE_MMM: state_s = ST_MMM;
      ST_MMM: begin
        if (step_last_s) begin
          state_s = ST_POST_MMM;
        end else begin
          step_s  = step_r + STEP_W'(1);
        end
      end
      ST_POST_MMM: begin
        step_s    = '0;
        round_s   = round_r + ROUND_W'(1);
        reg_exp_s = exp_shift_s;
        // Stop once no set bits remain above the one just consumed
        if (exp_shift_s == '0) begin
          state_s = ST_PRE_REMAP;
        end else begin
          state_s = ST_PRE_MMM;
        end
      end
      ST_PRE_REMAP: state_s = ST_REMAP;
      ST_REMAP: begin
        if (step_last_s) begin
          state_s = ST_POST_REMAP;
        end else begin
          step_s  = step_r + STEP_W'(1);
        end
      end
      ST_POST_REMAP: begin
        step_s  = '0;
        state_s = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          reg_exp_s = expE;
          round_s   = '0;
          state_s   = ST_PRE_MAP;
        end else begin
          state_s   = ST_DONE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        step_s    = '0;
        round_s   = '0;
        reg_exp_s = '0;
      end
    endcase
    if (abort && in_busy_s) begin
      state_s = ST_IDLE;
      step_s  = '0;
    end else begin
      state_s = state_s;
    end
  end

  // Output decode of the registered state
  always_comb begin
    rst_mmm = 1'b0;
    ld_a    = 1'b0;
    ld_r    = 1'b0;
    lock1   = 1'b0;
    lock2   = 1'b0;
    sel1    = 2'b00;
    sel2    = 1'b0;
    eoc     = 1'b0;
    busy    = in_busy_s;
    case (state_r)
      ST_PRE_MAP, ST_MAP: begin
        rst_mmm = 1'b1;
        ld_a    = 1'b1;
        lock1   = 1'b1;
        lock2   = 1'b1;
      end
      ST_POST_MAP: begin
        rst_mmm = 1'b1;
        ld_r    = 1'b1;
        lock1   = 1'b1;
        lock2   = 1'b1;
      end
      ST_PRE_MMM, ST_MMM, ST_POST_MMM: begin
        rst_mmm = 1'b1;
        ld_a    = (state_r == ST_PRE_MMM);
        ld_r    = (state_r == ST_POST_MMM);
        lock1   = reg_exp_r[0];
        lock2   = 1'b1;
        sel1    = 2'b01;
        sel2    = 1'b1;
      end
      ST_PRE_REMAP, ST_REMAP, ST_POST_REMAP: begin
        rst_mmm = 1'b1;
        ld_a    = (state_r == ST_PRE_REMAP);
        ld_r    = (state_r == ST_POST_REMAP);
        lock1   = 1'b1;
        sel1    = 2'b10;
        sel2    = 1'b1;
      end
      ST_DONE: begin
        rst_mmm = 1'b1;
        lock1   = 1'b1;
        sel1    = 2'b10;
        sel2    = 1'b1;
        eoc     = 1'b1;
      end
      default: begin
        rst_mmm = 1'b0;
        busy    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rsa_ctrl_fsm_v2.sv
// Scoreboard bench for rsa_ctrl_fsm_v2: each operation's expected latency, round count and
// per-phase output statistics come from a phase-level model and are checked when the operation ends.
`timescale 1ns/1ps
module tb_rsa_ctrl_fsm_v2;

  localparam int W  = 8;
  localparam int EW = 8;
  localparam int P  = W + 3;

  logic       clk = 1'b0;
  logic       rstb, ena, start, abort;
  logic [7:0] expE;
  logic       rst_mmm, ld_a, ld_r, lock1, lock2, sel2, busy, eoc;
  logic [1:0] sel1;
  logic [3:0] round;
  logic [7:0] vec;

  assign vec = {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2};

  rsa_ctrl_fsm_v2 #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .start(start), .abort(abort), .expE(expE),
    .rst_mmm(rst_mmm), .ld_a(ld_a), .ld_r(ld_r), .lock1(lock1), .lock2(lock2),
    .sel1(sel1), .sel2(sel2), .busy(busy), .eoc(eoc), .round(round)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         aborted;
    logic [7:0] e;
    int         wall, en_lat, rnd;
    int         n_busy, n_lda, n_ldr, n_lock1, n_lock2, n_s00, n_s01, n_s10, n_sel2;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Phase-level reference: map and remap always run, plus one phase per exponent bit up to the top set bit
  function automatic exp_t model(input logic [7:0] e, input bit ab, input int wall);
    exp_t x;
    int r, pc;
    r = 0; pc = 0;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) begin
        r = i + 1;
        pc++;
      end
    end
    x.aborted = ab;  x.e = e;  x.wall = wall;  x.rnd = r;
    x.en_lat  = (2 + r) * P;
    x.n_busy  = (2 + r) * P;
    x.n_lda   = (W + 2) + r + 1;
    x.n_ldr   = 2 + r;
    x.n_lock1 = (2 + pc) * P;
    x.n_lock2 = (1 + r) * P;
    x.n_s00   = P;
    x.n_s01   = r * P;
    x.n_s10   = P;
    x.n_sel2  = (1 + r) * P;
    return x;
  endfunction

  // Edge bookkeeping for latency measurement
  longint tot_edges = 0, tot_en = 0;
  logic   last_en = 1'b1;
  int     rst_cnt = 0;
  always @(posedge clk) begin
    tot_edges <= tot_edges + 1;
    if (ena) tot_en <= tot_en + 1;
    last_en <= ena;
  end
  always @(negedge rstb) rst_cnt <= rst_cnt + 1;

  // Monitor
  logic        pbusy = 1'b0, peoc = 1'b0;
  logic [11:0] pst = '0, cur;
  int          rs = 0;
  longint      base_tot = 0, base_en = 0;
  int          c_busy, c_lda, c_ldr, c_lock1, c_lock2, c_s00, c_s01, c_s10, c_sel2, nr;
  logic [7:0]  lseq;
  exp_t        mx;

  task automatic compare_done(input exp_t x);
    chk("end_kind_done", 0, x.aborted);
    chk("done_vec", vec, 8'h95);
    chk("done_busy", busy, 0);
    chk("latency_enabled", tot_en - base_en, x.en_lat);
    if (x.wall >= 0) chk("latency_cycles", tot_edges - base_tot, x.wall);
    chk("round", round, x.rnd);
    chk("lock1_rounds", nr, x.rnd);
    chk("lock1_sequence", lseq, x.e);
    chk("busy_cycles", c_busy, x.n_busy);
    chk("ld_a_cycles", c_lda, x.n_lda);
    chk("ld_r_cycles", c_ldr, x.n_ldr);
    chk("lock1_cycles", c_lock1, x.n_lock1);
    chk("lock2_cycles", c_lock2, x.n_lock2);
    chk("sel1_map_cycles", c_s00, x.n_s00);
    chk("sel1_loop_cycles", c_s01, x.n_s01);
    chk("sel1_remap_cycles", c_s10, x.n_s10);
    chk("sel2_cycles", c_sel2, x.n_sel2);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cur = {vec, round};
      if (!last_en && rstb && rst_cnt == rs) chk("hold_when_ena_low", cur, pst);
      rs = rst_cnt;
      if (busy && !pbusy) begin
        base_tot = tot_edges; base_en = tot_en;
        c_busy = 0; c_lda = 0; c_ldr = 0; c_lock1 = 0; c_lock2 = 0;
        c_s00 = 0; c_s01 = 0; c_s10 = 0; c_sel2 = 0; nr = 0; lseq = '0;
      end
      if (busy && last_en) begin
        c_busy++;
        if (ld_a)  c_lda++;
        if (ld_r)  c_ldr++;
        if (lock1) c_lock1++;
        if (lock2) c_lock2++;
        if (sel2)  c_sel2++;
        if (sel1 == 2'b00) c_s00++;
        if (sel1 == 2'b01) c_s01++;
        if (sel1 == 2'b10) c_s10++;
        if (sel1 == 2'b01 && ld_r) begin
          if (nr < 8) lseq[nr] = lock1;
          nr++;
        end
      end
      if ((eoc && !peoc) || (!busy && pbusy && !eoc)) begin
        if (sb.size() == 0) begin
          chk("unexpected_end", 0, 1);
        end else begin
          mx = sb.pop_front();
          if (eoc) compare_done(mx);
          else     chk("end_kind_abort", 1, mx.aborted);
        end
      end
      pbusy = busy; peoc = eoc; pst = cur;
    end
  end

  // mode 0: ena high, 1: random ena, 2: ena alternating 0/1; abort_at <0 picks a random enabled edge
  task automatic run_op(input logic [7:0] e, input int mode, input int abort_at, input int wall);
    exp_t x;
    int   ab_at, en, cyc;
    bit   fin;
    x = model(e, 1'b0, wall);
    ab_at = abort_at;
    if (ab_at < 0) ab_at = $urandom_range(x.en_lat - 1, 1);
    x.aborted = (ab_at > 0);
    sb.push_back(x);
    start = 1'b1; expE = e; ena = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; expE = 8'($urandom);
    en = 0; cyc = 0; fin = 1'b0;
    while (!fin) begin
      if (ab_at > 0 && en + 1 == ab_at) begin
        abort = 1'b1; ena = 1'b1;
      end else if (mode == 1) ena = ($urandom_range(3, 0) != 0);
      else if (mode == 2)     ena = (cyc % 2 == 1);
      else                    ena = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (ena) en++;
      if (abort) begin
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_eoc", eoc, 0);
        chk("abort_idle_vec", vec, 0);
        fin = 1'b1;
      end else if (eoc) begin
        fin = 1'b1;
      end else if (cyc > 2000) begin
        chk("op_timeout", 0, 1);
        fin = 1'b1;
      end
    end
    ena = 1'b1;
  endtask

  task automatic wait_eoc(input int budget);
    int n;
    n = 0;
    while (!eoc && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!eoc) chk("eoc_timeout", 0, 1);
  endtask

  initial begin
    rstb = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; expE = 8'h00;
    #1;
    chk("reset_vec", vec, 0);
    chk("reset_busy", busy, 0);
    chk("reset_eoc", eoc, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vec_clocked", vec, 0);
    chk("reset_round", round, 0);
    rstb = 1'b1;
    @(posedge clk); #1;

    run_op(8'h0B, 0, 0, 66);
    run_op(8'h00, 0, 0, 22);
    run_op(8'h80, 0, 0, 110);
    run_op(8'hFF, 0, 26, -1);
    run_op(8'h01, 0, 0, 33);

    // start held through an operation: relaunch from DONE with the expE present at that moment
    sb.push_back(model(8'h05, 1'b0, 55));
    sb.push_back(model(8'h02, 1'b0, 44));
    start = 1'b1; expE = 8'h05;
    @(posedge clk); #1;
    expE = 8'h02;
    wait_eoc(200);
    @(posedge clk); #1;
    chk("held_start_busy", busy, 1);
    chk("held_start_round", round, 0);
    chk("held_start_vec", vec, 8'hD8);
    start = 1'b0; expE = 8'h00;
    wait_eoc(200);

    run_op(8'h03, 2, 0, 88);

    // asynchronous reset in the middle of MAP
    sb.push_back(model(8'h0F, 1'b1, -1));
    start = 1'b1; expE = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    chk("async_rst_vec", vec, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_eoc", eoc, 0);
    chk("async_rst_round", round, 0);
    @(posedge clk); #1;
    rstb = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      logic [7:0] e;
      e = 8'($urandom);
      if (i % 5 == 0) e = 8'($urandom_range(3, 0));
      run_op(e, (i % 2), ($urandom_range(3, 0) == 0) ? -1 : 0, -1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rsa_ctrl_fsm_v2.md
# rsa_ctrl_fsm_v2

Parametrised control sequencer for the RSA modular-exponentiation datapath. It drives the two Montgomery multipliers (MMM), the operand and result registers and the input muxes through three phases: map, square-and-multiply rounds, and remap. Compared with the first-generation controller, it adds a start/done/abort handshake and independent operand and exponent widths. It also runs only as many rounds as the exponent's bit length, and returns to idle so back-to-back operations are possible.

## Interface
- `WIDTH`, default 8: modulus/operand width; each MMM phase lasts `WIDTH+1` cycles.
- `EXP_WIDTH`, default 8: exponent width.
- `clk` input 1: clock; all state changes on its rising edge.
- `rstb` input 1: reset, asynchronous and active-low.
- `ena` input 1: global clock enable; when 0, all registers hold.
- `start` input 1: request an operation; sampled in IDLE and DONE.
- `abort` input 1: cancel the operation in progress.
- `expE` input `EXP_WIDTH`: exponent; captured when `start` is accepted.
- `rst_mmm` output 1: active-low MMM reset.
- `ld_a` output 1: load MMM operand registers.
- `ld_r` output 1: capture MMM results.
- `lock1` output 1: enable multiply-MMM result update.
- `lock2` output 1: enable square-MMM result update.
- `sel1` output 2: operand mux select; 00 = map, 01 = loop, 10 = remap.
- `sel2` output 1: second-operand mux select.
- `busy` output 1: high in every state except IDLE and DONE.
- `eoc` output 1: end of computation; high in DONE.
- `round` output `$clog2(EXP_WIDTH+1)`: completed rounds in the current operation.

## Operation
- Internal registers:
  - `step` counter, `$clog2(WIDTH+1)` bits.
  - `round` counter.
  - `reg_exp` shift register, `EXP_WIDTH` bits.
- All register updates are qualified by `ena=1`. `rstb` low → state IDLE and all registers 0.
- States and transitions:
  - IDLE: `step` and `round` are cleared. `start=1` → `reg_exp←expE`, go to PRE_MAP.
  - PRE_MAP → MAP.
  - MAP: `step++`. When `step==WIDTH`, go to POST_MAP.
  - POST_MAP: `step←0`. If `reg_exp==0`, go to PRE_REMAP; otherwise go to PRE_MMM.
  - PRE_MMM → MMM.
  - MMM: `step++`. When `step==WIDTH`, go to POST_MMM.
  - POST_MMM: `step←0`, `round++`, `reg_exp←reg_exp>>1`. If `(reg_exp>>1)==0`, go to PRE_REMAP; otherwise go to PRE_MMM.
  - PRE_REMAP → REMAP.
  - REMAP: `step++`. When `step==WIDTH`, go to POST_REMAP.
  - POST_REMAP: `step←0`, go to DONE.
  - DONE: `start=1` → `reg_exp←expE`, `round←0`, go to PRE_MAP; otherwise hold.
- Outputs per state, listed as `rst_mmm`, `ld_a`, `ld_r`, `lock1`, `lock2`, `sel1`, `sel2`:
  - IDLE: 0,0,0,0,0,00,0.
  - PRE_MAP: 1,1,0,1,1,00,0.
  - MAP: 1,1,0,1,1,00,0.
  - POST_MAP: 1,0,1,1,1,00,0.
  - PRE_MMM: 1,1,0,`reg_exp[0]`,1,01,1.
  - MMM: 1,0,0,`reg_exp[0]`,1,01,1.
  - POST_MMM: 1,0,1,`reg_exp[0]`,1,01,1.
  - PRE_REMAP: 1,1,0,1,0,10,1.
  - REMAP: 1,0,0,1,0,10,1.
  - POST_REMAP: 1,0,1,1,0,10,1.
  - DONE: 1,0,0,1,0,10,1, with `eoc=1`.
- Outputs are a combinational decode of the registered state. Reset values: every output 0 (IDLE).
- `abort=1` with `ena=1` in any busy state → IDLE on the next edge; `eoc` is not asserted. `abort` has priority over every transition. `abort` in IDLE or DONE is ignored.
- `start` while busy is ignored; `expE` changes while busy have no effect.
- Unreachable state encodings decode to IDLE outputs and go to IDLE.

## Timing
- Each phase (PRE + body + POST) lasts `P = WIDTH+3` cycles.
- `R` = bit length of `expE`: index of the MSB set, plus 1; `R=0` for `expE=0`.
- `start` is sampled at edge 0, giving PRE_MAP after edge 0. `eoc` rises `(2+R)·P` cycles after edge 0.
- `ena=0` stretches the latency by one cycle per low cycle; outputs stay constant while `ena=0`.
- `rstb` asserted mid-operation: outputs 0 immediately, without waiting for `clk`.
- `round` updates at the end of each POST_MMM cycle and stays valid in DONE until the next `start`.

## Test plan
- `WIDTH=8`, `expE=8'b0000_1011`, `start` pulse → `eoc` at cycle 66, `round=4`, `lock1` sequence across rounds 1,1,0,1.
- `expE=0` → MMM phase skipped, `eoc` at cycle 22, `round=0`.
- `expE=8'h80` → `eoc` at cycle 110, `round=8`; `lock1` is 1 only in round 8.
- `abort` during the MMM body of round 2 → IDLE on the next cycle, `busy=0`, `eoc=0`. A following `start` with `expE=1` → `eoc` at cycle 33.
- `start` held high in DONE → PRE_MAP the next cycle, with `round` cleared and the new `expE` captured.
- `ena` toggled 0/1 every cycle with `expE=3` → `eoc` at cycle 88 (44 enabled cycles); async `rstb` pulse mid-MAP → all outputs 0 before the next edge.
